// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem with variable latency,
// presents instr/pc_plus_2 to decode, and handles halt, misalignment and timeout.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_updated,
   input  logic        advance,
   input  logic        halt,
   input  logic [15:0] imem_data,
   input  logic        imem_done,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   output logic [15:0] instr,
   output logic [15:0] pc_plus_2,
   output logic        instr_valid,
   output logic [15:0] instr_count,
   output logic        halted,
   output logic        err
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned WAIT_W = 8;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_VALID  = 2'd1,
      S_HALTED = 2'd2,
      S_ERR    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [DATA_W-1:0]   count_q, count_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                rd_q, rd_d;
   logic                valid_q, valid_d;
   logic                halted_q, halted_d;
   logic                err_q, err_d;

   // State and datapath registers; reset is asynchronous so outputs drop at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         count_q  <= '0;
         wait_q   <= '0;
         rd_q     <= 1'b1;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         count_q  <= count_d;
         wait_q   <= wait_d;
         rd_q     <= rd_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      wait_d  = wait_q;

      case (state_q)
         S_FETCH: begin
            if (imem_done) begin
               instr_d = imem_data;
               wait_d  = '0;
               state_d = S_VALID;
            end else begin
               // A response on the TIMEOUT-th cycle still wins over the watchdog
               wait_d = wait_q + WAIT_W'(1);
               if (wait_d == WAIT_W'(TIMEOUT)) begin
                  state_d = S_ERR;
               end
            end
         end
         S_VALID: begin
            if (advance) begin
               count_d = count_q + DATA_W'(1);
               if (halt) begin
                  state_d = S_HALTED;
               end else if (pc_updated[0]) begin
                  state_d = S_ERR;
               end else begin
                  pc_d    = pc_updated;
                  state_d = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // Status flags registered from the next state so they track state_q exactly
   always_comb begin
      rd_d     = 1'b0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      err_d    = 1'b0;
      case (state_d)
         S_FETCH:  rd_d     = 1'b1;
         S_VALID:  valid_d  = 1'b1;
         S_HALTED: halted_d = 1'b1;
         S_ERR:    err_d    = 1'b1;
         default:  err_d    = 1'b1;
      endcase
   end

   assign imem_addr   = pc_q;
   assign imem_rd     = rd_q;
   assign instr       = instr_q;
   assign pc_plus_2   = pc_q + DATA_W'(2);
   assign instr_valid = valid_q;
   assign instr_count = count_q;
   assign halted      = halted_q;
   assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (TIMEOUT set to 4 for the watchdog cases).
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [15:0] pc_updated;
   logic        advance;
   logic        halt;
   logic [15:0] imem_data;
   logic        imem_done;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] instr;
   logic [15:0] pc_plus_2;
   logic        instr_valid;
   logic [15:0] instr_count;
   logic        halted;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_updated  (pc_updated),
      .advance     (advance),
      .halt        (halt),
      .imem_data   (imem_data),
      .imem_done   (imem_done),
      .imem_addr   (imem_addr),
      .imem_rd     (imem_rd),
      .instr       (instr),
      .pc_plus_2   (pc_plus_2),
      .instr_valid (instr_valid),
      .instr_count (instr_count),
      .halted      (halted),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        adv;
      logic        hlt;
      logic [15:0] pcu;
      logic        done;
      logic [15:0] data;
      logic [15:0] e_addr;
      logic        e_rd;
      logic [15:0] e_instr;
      logic [15:0] e_pp2;
      logic        e_valid;
      logic [15:0] e_cnt;
      logic        e_halted;
      logic        e_err;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic adv, input logic hlt, input logic [15:0] pcu,
                               input logic done, input logic [15:0] data,
                               input logic [15:0] addr, input logic rd, input logic [15:0] ins,
                               input logic [15:0] pp2, input logic vld, input logic [15:0] cnt,
                               input logic hd, input logic er);
      vec_t v;
      v.adv = adv; v.hlt = hlt; v.pcu = pcu; v.done = done; v.data = data;
      v.e_addr = addr; v.e_rd = rd; v.e_instr = ins; v.e_pp2 = pp2;
      v.e_valid = vld; v.e_cnt = cnt; v.e_halted = hd; v.e_err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] addr, input logic rd,
                          input logic [15:0] ins, input logic [15:0] pp2, input logic vld,
                          input logic [15:0] cnt, input logic hd, input logic er);
      chk({tag, ".imem_addr"},   imem_addr,          addr);
      chk({tag, ".imem_rd"},     16'(imem_rd),       16'(rd));
      chk({tag, ".instr"},       instr,              ins);
      chk({tag, ".pc_plus_2"},   pc_plus_2,          pp2);
      chk({tag, ".instr_valid"}, 16'(instr_valid),   16'(vld));
      chk({tag, ".instr_count"}, instr_count,        cnt);
      chk({tag, ".halted"},      16'(halted),        16'(hd));
      chk({tag, ".err"},         16'(err),           16'(er));
   endtask

   task automatic drive(input logic adv, input logic hlt, input logic [15:0] pcu,
                        input logic done, input logic [15:0] data);
      advance    = adv;
      halt       = hlt;
      pc_updated = pcu;
      imem_done  = done;
      imem_data  = data;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      advance = 1'b0; halt = 1'b0; pc_updated = '0; imem_done = 1'b0; imem_data = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      // adv hlt pcu done data | addr rd instr pp2 valid cnt halted err
      tbl[0]  = mk(0,0,16'h0000,1,16'hC0DE, 16'h0000,0,16'hC0DE,16'h0002,1,16'd0,0,0);
      tbl[1]  = mk(1,0,16'h0002,0,16'h0000, 16'h0002,1,16'hC0DE,16'h0004,0,16'd1,0,0);
      tbl[2]  = mk(0,0,16'h0000,0,16'h0000, 16'h0002,1,16'hC0DE,16'h0004,0,16'd1,0,0);
      tbl[3]  = mk(0,0,16'h0000,0,16'h0000, 16'h0002,1,16'hC0DE,16'h0004,0,16'd1,0,0);
      tbl[4]  = mk(0,0,16'h0000,0,16'h0000, 16'h0002,1,16'hC0DE,16'h0004,0,16'd1,0,0);
      tbl[5]  = mk(0,0,16'h0000,1,16'h1234, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[6]  = mk(0,0,16'h0100,1,16'hFFFF, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[7]  = mk(0,0,16'h0100,1,16'hFFFF, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[8]  = mk(0,1,16'h0100,1,16'hFFFF, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[9]  = mk(0,0,16'h0101,1,16'hFFFF, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[10] = mk(0,0,16'h0100,1,16'hFFFF, 16'h0002,0,16'h1234,16'h0004,1,16'd1,0,0);
      tbl[11] = mk(1,0,16'hFFFE,0,16'h0000, 16'hFFFE,1,16'h1234,16'h0000,0,16'd2,0,0);
      tbl[12] = mk(0,0,16'h0000,1,16'hABCD, 16'hFFFE,0,16'hABCD,16'h0000,1,16'd2,0,0);
      tbl[13] = mk(1,0,16'h0010,0,16'h0000, 16'h0010,1,16'hABCD,16'h0012,0,16'd3,0,0);
      tbl[14] = mk(1,0,16'h0020,0,16'h0000, 16'h0010,1,16'hABCD,16'h0012,0,16'd3,0,0);
      tbl[15] = mk(0,0,16'h0000,0,16'h0000, 16'h0010,1,16'hABCD,16'h0012,0,16'd3,0,0);
      tbl[16] = mk(0,0,16'h0000,0,16'h0000, 16'h0010,1,16'hABCD,16'h0012,0,16'd3,0,0);
      tbl[17] = mk(0,0,16'h0000,1,16'h5555, 16'h0010,0,16'h5555,16'h0012,1,16'd3,0,0);
      tbl[18] = mk(1,0,16'h0011,0,16'h0000, 16'h0010,0,16'h5555,16'h0012,0,16'd4,0,1);
      tbl[19] = mk(1,0,16'h0020,1,16'h7777, 16'h0010,0,16'h5555,16'h0012,0,16'd4,0,1);

      // Reset values while rst is held low
      rst = 1'b0;
      advance = 1'b0; halt = 1'b0; pc_updated = '0; imem_done = 1'b0; imem_data = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all("reset", 16'h0000, 1'b1, 16'h0000, 16'h0002, 1'b0, 16'd0, 1'b0, 1'b0);
      rst = 1'b1;

      // Main table: zero-wait, 3-wait with stalled advance, wrap, timeout boundary, misalign
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].adv, tbl[i].hlt, tbl[i].pcu, tbl[i].done, tbl[i].data);
         chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_rd, tbl[i].e_instr,
                 tbl[i].e_pp2, tbl[i].e_valid, tbl[i].e_cnt, tbl[i].e_halted, tbl[i].e_err);
      end

      // Watchdog: imem_done held low for TIMEOUT edges
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 16'h0000, 0, 16'h0000);
         chk($sformatf("tmo_wait%0d.err", i), 16'(err), 16'd0);
         chk($sformatf("tmo_wait%0d.imem_rd", i), 16'(imem_rd), 16'd1);
      end
      drive(0, 0, 16'h0000, 0, 16'h0000);
      chk_all("tmo_expire", 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'd0, 1'b0, 1'b1);
      drive(0, 0, 16'h0000, 1, 16'h9999);
      chk("tmo_sticky.instr", instr, 16'h0000);

      // Halt with an aligned target; everything ignored afterwards
      do_reset();
      drive(0, 0, 16'h0000, 1, 16'h0BAD);
      drive(1, 1, 16'h0040, 0, 16'h0000);
      chk_all("halt40", 16'h0000, 1'b0, 16'h0BAD, 16'h0002, 1'b0, 16'd1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 16'h0002, 1, 16'h4444);
         chk($sformatf("halted%0d.imem_rd", i), 16'(imem_rd), 16'd0);
         chk($sformatf("halted%0d.cnt", i), instr_count, 16'd1);
         chk($sformatf("halted%0d.addr", i), imem_addr, 16'h0000);
         chk($sformatf("halted%0d.halted", i), 16'(halted), 16'd1);
      end

      // Halt wins over a misaligned target
      do_reset();
      drive(0, 0, 16'h0000, 1, 16'h0BAD);
      drive(1, 1, 16'h0011, 0, 16'h0000);
      chk_all("halt_vs_mis", 16'h0000, 1'b0, 16'h0BAD, 16'h0002, 1'b0, 16'd1, 1'b1, 1'b0);

      // Asynchronous reset during a pending read, then a late response
      do_reset();
      drive(0, 0, 16'h0000, 1, 16'h1111);
      drive(1, 0, 16'h0100, 0, 16'h0000);
      drive(0, 0, 16'h0000, 0, 16'h0000);
      drive(0, 0, 16'h0000, 0, 16'h0000);
      chk("pre_async.addr", imem_addr, 16'h0100);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 16'h0000, 1'b1, 16'h0000, 16'h0002, 1'b0, 16'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 16'h0000, 0, 16'h0000);
      end
      chk("post_rst_wait.err", 16'(err), 16'd0);
      drive(0, 0, 16'h0000, 1, 16'hBEEF);
      chk_all("late_done", 16'h0000, 1'b0, 16'hBEEF, 16'h0002, 1'b1, 16'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the WISC-SP13 datapath: holds the architectural PC, reads the instruction at PC from a variable-latency instruction memory, and presents `instr` and `pc_plus_2` to decode/execute. When the instruction is consumed, it loads the next PC that execute computes (`pc_updated`). It also provides halt handling, misaligned-PC detection and a memory-timeout watchdog.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `TIMEOUT`, 64: maximum cycles spent in FETCH waiting for `imem_done` (legal range 1..255).
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `pc_updated`  in  16  next PC from execute; sampled only on an accepted advance.
- `advance`  in  1  downstream has consumed the current instruction.
- `halt`  in  1  the current instruction is HALT; sampled only with `advance`.
- `imem_data`  in  16  instruction word; valid when `imem_done`=1.
- `imem_done`  in  1  memory read complete; may be asserted in the same cycle as `imem_rd` (zero-wait memory).
- `imem_addr`  out  16  read address, always equals the PC register.
- `imem_rd`  out  1  read request, level, high in state FETCH only.
- `instr`  out  16  latched instruction.
- `pc_plus_2`  out  16  PC + 2, modulo 2^16.
- `instr_valid`  out  1  `instr` and `pc_plus_2` are valid for consumption.
- `instr_count`  out  16  accepted advances since reset, wrapping.
- `halted`  out  1  processor halted (sticky).
- `err`  out  1  fatal fetch error (sticky).

## Operation
- States: FETCH, VALID, HALTED, ERR. Reset state is FETCH.
- Reset values: PC=`RESET_PC`, `instr`=16'h0000, `instr_count`=0, wait counter=0, `instr_valid`=0, `halted`=0, `err`=0.
- FETCH:
  - `imem_rd`=1.
  - On an edge with `imem_done`=1: latch `imem_data` into `instr`, clear the wait counter, go to VALID.
  - Otherwise the wait counter increments. If the counter reaches `TIMEOUT` (i.e., `TIMEOUT` edges with `imem_done`=0), go to ERR.
- VALID:
  - `instr_valid`=1 and `imem_rd`=0.
  - `instr` and PC are held while `advance`=0, for an unbounded number of cycles.
  - On `advance`=1, `instr_count` increments in every case, then:
    - if `halt`=1, go to HALTED with PC unchanged;
    - else if `pc_updated[0]`=1, go to ERR with PC unchanged;
    - else PC←`pc_updated` and go to FETCH.
  - `halt` has priority over the misalignment check.
- HALTED: `halted`=1, `instr_valid`=0, `imem_rd`=0. All inputs are ignored until reset.
- ERR: `err`=1, `instr_valid`=0, `imem_rd`=0. All inputs are ignored until reset.
- `advance` outside VALID is ignored: no count, no PC load.
- `imem_done` outside FETCH is ignored.
- `pc_plus_2` is combinational from PC; 16'hFFFE gives 16'h0000, with no error.
- `imem_addr` equals PC in all states.

## Timing
- Zero-wait memory: FETCH lasts 1 cycle, so `instr_valid` rises on the edge after FETCH is entered.
- Memory with N wait cycles: `instr_valid` rises N+1 edges after FETCH is entered.
- Back-to-back throughput, with `advance` held high: one instruction per 2 cycles (FETCH, VALID).
- `pc_updated` is loaded on the same edge that accepts `advance`. The new address appears on `imem_addr` in the following FETCH cycle.
- Timeout boundary: `imem_done` arriving on the `TIMEOUT`-th FETCH cycle is accepted; ERR is entered only if it is still low on that edge.
- Reset asserted mid-operation (any state, including a FETCH with a pending read): all outputs take their reset values immediately, without waiting for `clk`. A late `imem_done` after reset release is treated as a response to the new FETCH at `RESET_PC`.
- `halted` and `err` never both assert.

## Test plan
- Zero-wait memory returning 16'hC0DE at address 0, then `advance`=1 with `pc_updated`=16'h0002: `instr`=16'hC0DE and `pc_plus_2`=16'h0002 with `instr_valid` in cycle 2; `imem_addr`=16'h0002 in cycle 3; `instr_count`=1.
- Memory with 3 wait cycles and `advance` held low for 5 cycles in VALID: `instr_valid` rises 4 edges after FETCH; `instr` and PC stay stable for all 5 cycles; `instr_count` unchanged.
- Advance with `halt`=1 and `pc_updated`=16'h0040: `halted`=1, PC unchanged, `imem_rd` stays 0 for 20 further cycles, and later advances are ignored.
- Advance with `pc_updated`=16'h0011: ERR state, `err`=1, `imem_addr` remains at the old PC. Repeat with `halt`=1 at the same time: HALTED wins, `err`=0.
- `TIMEOUT`=4 with `imem_done` held low: `err`=1 after the 4th FETCH edge. Second run with `imem_done` on the 4th cycle: the instruction is accepted and `err`=0.
- Branch to 16'hFFFE: `pc_plus_2`=16'h0000. Drive `rst`=0 asynchronously mid-wait: all outputs return to reset values before the next edge, and the fetch restarts at 16'h0000.
